// File: rtl/status_snapshot_ctrl_pkg.sv
// Shared constants, FSM encoding and address rules for the status snapshot controller.
package status_snapshot_ctrl_pkg;

    localparam int unsigned NRegs  = 34;
    localparam int unsigned AddrW  = 6;
    localparam logic [7:0]  HdrTag = 8'h5A;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StHeader,
        StStream
    } state_e;

    // Addresses past the {dropped, seq} word are reported as bus errors.
    function automatic logic ipb_addr_err(input logic [AddrW-1:0] addr);
        return 32'(addr) > NRegs;
    endfunction

endpackage

// File: rtl/status_snapshot_ctrl_if.sv
// Stream output and IPbus read port of the snapshot controller.
interface status_snapshot_ctrl_if;
    import status_snapshot_ctrl_pkg::*;

    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [AddrW-1:0] ipb_addr;
    logic             ipb_strobe;
    logic [31:0]      ipb_rdata;
    logic             ipb_ack;
    logic             ipb_err;

    modport master (
        output out_data, out_valid, out_last, ipb_rdata, ipb_ack, ipb_err,
        input  out_ready, ipb_addr, ipb_strobe
    );

    modport slave (
        input  out_data, out_valid, out_last, ipb_rdata, ipb_ack, ipb_err,
        output out_ready, ipb_addr, ipb_strobe
    );

endinterface

// File: rtl/status_snapshot_ctrl_snap_timer.sv
// Periodic snapshot trigger: single-cycle fire every period_i cycles, idle when period_i is 0.
module status_snapshot_ctrl_snap_timer (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] period_i,
    output logic        fire_o
);

    logic [31:0] count_q, count_d;

    // A period shrinking below the count fires on the very next cycle via the >= compare.
    always_comb begin
        fire_o = (period_i != 32'd0) && (count_q >= period_i - 32'd1);
        if (period_i == 32'd0 || fire_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/status_snapshot_ctrl.sv
// Coherent snapshot of the status bank into a shadow bank, served over IPbus and streamed.
module status_snapshot_ctrl
    import status_snapshot_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [NRegs*32-1:0]   status_flat_i,
    input  logic                  snap_req_i,
    input  logic [31:0]           snap_period_i,
    input  logic                  stream_en_i,
    status_snapshot_ctrl_if.master bus,
    output logic [15:0]           snap_seq_o,
    output logic [15:0]           snap_dropped_o,
    output logic                  snap_busy_o
);

    localparam logic [5:0] LastIdx = 6'(NRegs - 1);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] dropped_q, dropped_d;
    logic        busy_q;
    logic [31:0] shadow_q [NRegs];
    logic [31:0] ipb_rdata_q, ipb_rdata_d;
    logic        ipb_ack_q, ipb_err_q;
    logic        timer_fire, ext_trig, trigger;
    logic        accept;

    status_snapshot_ctrl_snap_timer u_timer (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .period_i (snap_period_i),
        .fire_o   (timer_fire)
    );

    assign ext_trig = snap_req_i | timer_fire;
    assign trigger  = ext_trig | pending_q;
    assign accept   = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle:    if (trigger) state_d = StCapture;
            StCapture: state_d = stream_en_i ? StHeader : StIdle;
            StHeader: begin
                if (accept) begin
                    state_d = StStream;
                    idx_d   = '0;
                end
            end
            StStream: begin
                if (accept) begin
                    if (idx_q == LastIdx) state_d = StIdle;
                    else                  idx_d   = idx_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        unique case (state_q)
            StHeader: begin
                bus.out_valid = 1'b1;
                bus.out_data  = {HdrTag, 8'(NRegs), seq_q};
            end
            StStream: begin
                bus.out_valid = 1'b1;
                bus.out_last  = (idx_q == LastIdx);
                bus.out_data  = shadow_q[idx_q];
            end
            default: ;
        endcase
    end

    // A trigger landing in CAPTURE becomes the next pending snapshot rather than a drop.
    always_comb begin
        pending_d = pending_q;
        seq_d     = seq_q;
        dropped_d = dropped_q;
        if (state_q == StCapture) begin
            seq_d     = seq_q + 16'd1;
            pending_d = ext_trig;
        end else if (state_q != StIdle && ext_trig) begin
            if (!pending_q)                  pending_d = 1'b1;
            else if (dropped_q != 16'hFFFF)  dropped_d = dropped_q + 16'd1;
        end
    end

    always_comb begin
        ipb_rdata_d = '0;
        if (32'(bus.ipb_addr) < NRegs)       ipb_rdata_d = shadow_q[bus.ipb_addr];
        else if (32'(bus.ipb_addr) == NRegs) ipb_rdata_d = {dropped_q, seq_q};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            seq_q       <= '0;
            dropped_q   <= '0;
            busy_q      <= 1'b0;
            ipb_rdata_q <= '0;
            ipb_ack_q   <= 1'b0;
            ipb_err_q   <= 1'b0;
            for (int k = 0; k < NRegs; k++) shadow_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            seq_q       <= seq_d;
            dropped_q   <= dropped_d;
            busy_q      <= (state_d != StIdle);
            ipb_ack_q   <= bus.ipb_strobe;
            ipb_rdata_q <= bus.ipb_strobe ? ipb_rdata_d : 32'd0;
            ipb_err_q   <= bus.ipb_strobe & ipb_addr_err(bus.ipb_addr);
            if (state_q == StCapture) begin
                for (int k = 0; k < NRegs; k++) shadow_q[k] <= status_flat_i[32*k +: 32];
            end
        end
    end

    assign bus.ipb_rdata   = ipb_rdata_q;
    assign bus.ipb_ack     = ipb_ack_q;
    assign bus.ipb_err     = ipb_err_q;
    assign snap_seq_o      = seq_q;
    assign snap_dropped_o  = dropped_q;
    assign snap_busy_o     = busy_q;

endmodule

// File: tb/tb_status_snapshot_ctrl.sv
// Directed/randomised bench for status_snapshot_ctrl with a packet-level reference model.
module tb_status_snapshot_ctrl;
    import status_snapshot_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NRegs*32-1:0] status_flat;
    logic                snap_req;
    logic [31:0]         snap_period;
    logic                stream_en;
    logic [15:0]         snap_seq, snap_dropped;
    logic                snap_busy;

    status_snapshot_ctrl_if bus ();

    status_snapshot_ctrl dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .status_flat_i  (status_flat),
        .snap_req_i     (snap_req),
        .snap_period_i  (snap_period),
        .stream_en_i    (stream_en),
        .bus            (bus),
        .snap_seq_o     (snap_seq),
        .snap_dropped_o (snap_dropped),
        .snap_busy_o    (snap_busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur        [NRegs];
    logic [31:0] exp_shadow [NRegs];
    logic [15:0] m_seq;
    logic [15:0] m_dropped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_status();
        for (int k = 0; k < NRegs; k++) begin
            cur[k] = $urandom;
            status_flat[32*k +: 32] = cur[k];
        end
    endtask

    task automatic snapshot_model();
        for (int k = 0; k < NRegs; k++) exp_shadow[k] = cur[k];
    endtask

    task automatic pulse_req();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
    endtask

    // Strobe stays high on return so callers can issue back-to-back reads.
    task automatic ipb_read(input logic [5:0] a, input logic [31:0] exp, input logic exp_err);
        bus.ipb_addr   = a;
        bus.ipb_strobe = 1'b1;
        step();
        chk("ipb_ack", 32'(bus.ipb_ack), 32'd1);
        chk("ipb_rdata", bus.ipb_rdata, exp);
        chk("ipb_err", 32'(bus.ipb_err), 32'(exp_err));
    endtask

    // Consume one header plus NRegs words, optionally stalling on alternate cycles.
    task automatic run_packet(input bit stall, input logic [15:0] seq);
        int          beat = 0;
        int          cyc  = 0;
        bit          phase = 1'b1;
        bit          was_stalled = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] want;
        while (beat < NRegs + 1 && cyc < 400) begin
            bus.out_ready = stall ? phase : 1'b1;
            phase = ~phase;
            if (bus.out_valid) begin
                want = (beat == 0) ? {HdrTag, 8'(NRegs), seq} : exp_shadow[beat-1];
                chk("beat_data", bus.out_data, want);
                chk("beat_last", 32'(bus.out_last), 32'(beat == NRegs));
                if (was_stalled) chk("stall_hold", bus.out_data, held);
                was_stalled = !bus.out_ready;
                held        = bus.out_data;
                if (bus.out_ready) beat++;
            end
            step();
            cyc++;
        end
        chk("packet_beats", 32'(beat), 32'(NRegs + 1));
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_valid;
        reset_n        = 1'b0;
        snap_req       = 1'b0;
        snap_period    = '0;
        stream_en      = 1'b0;
        status_flat    = '0;
        bus.out_ready  = 1'b1;
        bus.ipb_strobe = 1'b0;
        bus.ipb_addr   = '0;
        m_seq          = '0;
        m_dropped      = '0;
        for (int k = 0; k < NRegs; k++) exp_shadow[k] = '0;

        repeat (3) step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_ipb_ack", 32'(bus.ipb_ack), 32'd0);
        chk("rst_ipb_err", 32'(bus.ipb_err), 32'd0);
        chk("rst_ipb_rdata", bus.ipb_rdata, 32'd0);
        chk("rst_busy", 32'(snap_busy), 32'd0);
        chk("rst_seq", 32'(snap_seq), 32'd0);
        chk("rst_dropped", 32'(snap_dropped), 32'd0);
        reset_n = 1'b1;
        step();
        ipb_read(6'd3, 32'd0, 1'b0);
        bus.ipb_strobe = 1'b0;
        step();
        chk("ipb_ack_drop", 32'(bus.ipb_ack), 32'd0);

        // Basic streamed snapshot with a known word 5.
        set_status();
        cur[5] = 32'h1234_5678;
        status_flat[32*5 +: 32] = cur[5];
        stream_en = 1'b1;
        pulse_req();
        chk("capture_busy", 32'(snap_busy), 32'd1);
        chk("capture_no_valid", 32'(bus.out_valid), 32'd0);
        m_seq = m_seq + 16'd1;
        snapshot_model();
        step();
        chk("first_header", bus.out_data, 32'h5A22_0001);
        run_packet(1'b0, m_seq);
        chk("idle_busy", 32'(snap_busy), 32'd0);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);

        // Periodic capture without streaming.
        set_status();
        stream_en   = 1'b0;
        snap_period = 32'd100;
        seen_valid  = 0;
        for (int i = 1; i <= 510; i++) begin
            step();
            if (bus.out_valid) seen_valid++;
            if (i == 250) chk("timer_seq_mid", 32'(snap_seq), 32'(m_seq + 16'd2));
        end
        snap_period = '0;
        m_seq = m_seq + 16'd5;
        snapshot_model();
        chk("timer_seq", 32'(snap_seq), 32'(m_seq));
        chk("timer_no_valid", 32'(seen_valid), 32'd0);
        ipb_read(6'd7, exp_shadow[7], 1'b0);
        bus.ipb_strobe = 1'b0;
        step();

        // A read issued in the CAPTURE cycle sees the pre-capture shadow.
        set_status();
        pulse_req();
        ipb_read(6'd0, exp_shadow[0], 1'b0);
        bus.ipb_strobe = 1'b0;
        m_seq = m_seq + 16'd1;
        snapshot_model();
        step();
        ipb_read(6'd0, exp_shadow[0], 1'b0);
        bus.ipb_strobe = 1'b0;
        step();

        // Three requests during one packet: one pending, two dropped.
        set_status();
        stream_en = 1'b1;
        pulse_req();
        m_seq = m_seq + 16'd1;
        snapshot_model();
        step();
        bus.out_ready = 1'b0;
        repeat (3) begin
            pulse_req();
            step();
        end
        m_dropped = m_dropped + 16'd2;
        chk("dropped_count", 32'(snap_dropped), 32'(m_dropped));
        set_status();
        run_packet(1'b1, m_seq);
        m_seq = m_seq + 16'd1;
        snapshot_model();
        run_packet(1'b0, m_seq);
        chk("pending_seq", 32'(snap_seq), 32'(m_seq));
        chk("pending_dropped", 32'(snap_dropped), 32'(m_dropped));
        step();
        chk("pending_idle", 32'(snap_busy), 32'd0);

        // Back-to-back IPbus reads: shadow word, status word, bad address.
        ipb_read(6'd3, exp_shadow[3], 1'b0);
        ipb_read(6'd34, {m_dropped, m_seq}, 1'b0);
        ipb_read(6'd40, 32'd0, 1'b1);
        bus.ipb_strobe = 1'b0;
        step();
        chk("ipb_ack_end", 32'(bus.ipb_ack), 32'd0);

        // Reset in the middle of a streamed packet.
        set_status();
        pulse_req();
        repeat (6) step();
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        step();
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_busy", 32'(snap_busy), 32'd0);
        chk("reset_seq", 32'(snap_seq), 32'd0);
        chk("reset_dropped", 32'(snap_dropped), 32'd0);
        reset_n   = 1'b1;
        m_seq     = '0;
        m_dropped = '0;
        for (int k = 0; k < NRegs; k++) exp_shadow[k] = '0;
        step();
        ipb_read(6'd0, 32'd0, 1'b0);
        bus.ipb_strobe = 1'b0;
        step();
        pulse_req();
        m_seq = m_seq + 16'd1;
        snapshot_model();
        run_packet(1'b0, m_seq);
        chk("post_reset_seq", 32'(snap_seq), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
